// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, decode bundle.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package decode_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_AW    = 5;
   localparam int OPC_W     = 6;
   localparam int FUNCT_W   = 6;
   localparam int SHAMT_W   = 5;
   localparam int IMM_W     = 16;

   localparam int OPC_LSB   = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_LSB   = 0;

   localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OPC_W-1:0] OP_LW    = 6'h23;

   // Everything execute needs for one decoded instruction.
   typedef struct packed {
      logic [DATA_W-1:0]  pc;
      logic [OPC_W-1:0]   opcode;
      logic [FUNCT_W-1:0] funct;
      logic [SHAMT_W-1:0] shamt;
      logic [DATA_W-1:0]  rs_data;
      logic [DATA_W-1:0]  rt_data;
      logic [DATA_W-1:0]  imm;
      logic [REG_AW-1:0]  dest;
      logic               reg_write;
   } decode_bundle_t;

endpackage

// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port, write-to-read bypass.
// Latency: reads combinational, writes visible after the clock edge (same cycle via bypass).
// Backpressure: none; writes are always accepted.
module register_file
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rd2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_live;

   assign wr_live = we && (wa != '0);

   // Storage update; reset clears every entry so no stale value survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wa] <= wd;
      end
   end

   // Read ports: r0 is hardwired zero, a same-cycle write is forwarded.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) rd1 = (wr_live && wa == ra1) ? wd : regs[ra1];
      if (ra2 != '0) rd2 = (wr_live && wa == ra2) ? wd : regs[ra2];
   end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: register read, immediate extension, destination select into an output register.
// Latency: 1 cycle from fetch handshake to id_* outputs.
// Backpressure: if_ready = !id_valid || id_ready; a held bundle waits for execute, flush drops it.
module instruction_decode
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [XLEN-1:0]   if_pc,
   input  logic [31:0]       if_instr,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [XLEN-1:0]   id_pc,
   output logic [OPC_W-1:0]  id_opcode,
   output logic [FUNCT_W-1:0] id_funct,
   output logic [SHAMT_W-1:0] id_shamt,
   output logic [XLEN-1:0]   id_rs_data,
   output logic [XLEN-1:0]   id_rt_data,
   output logic [XLEN-1:0]   id_imm,
   output logic [REG_AW-1:0] id_dest,
   output logic              id_reg_write
);

   logic [OPC_W-1:0]  opcode;
   logic [REG_AW-1:0] rs_idx;
   logic [REG_AW-1:0] rt_idx;
   logic [REG_AW-1:0] rd_idx;
   logic [IMM_W-1:0]  imm16;
   logic [XLEN-1:0]   rs_val;
   logic [XLEN-1:0]   rt_val;
   logic              capture;
   logic              wb_live;
   decode_bundle_t    nxt;
   decode_bundle_t    q;
   logic [REG_AW-1:0] held_rs;
   logic [REG_AW-1:0] held_rt;

   assign opcode  = if_instr[OPC_LSB +: OPC_W];
   assign rs_idx  = if_instr[RS_LSB +: REG_AW];
   assign rt_idx  = if_instr[RT_LSB +: REG_AW];
   assign rd_idx  = if_instr[RD_LSB +: REG_AW];
   assign imm16   = if_instr[IMM_LSB +: IMM_W];

   assign if_ready = !id_valid || id_ready;
   assign capture  = if_valid && if_ready && !flush;
   assign wb_live  = wb_en && (wb_addr != '0);

   register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs_idx),
      .ra2 (rt_idx),
      .rd1 (rs_val),
      .rd2 (rt_val),
      .we  (wb_en),
      .wa  (wb_addr),
      .wd  (wb_data)
   );

   // Build the next bundle from the presented instruction.
   always_comb begin
      nxt         = '0;
      nxt.pc      = if_pc;
      nxt.opcode  = opcode;
      nxt.funct   = if_instr[FUNCT_LSB +: FUNCT_W];
      nxt.shamt   = if_instr[SHAMT_LSB +: SHAMT_W];
      nxt.rs_data = rs_val;
      nxt.rt_data = rt_val;
      // Logical immediates are unsigned; everything else sign-extends.
      if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
         nxt.imm = {{(XLEN-IMM_W){1'b0}}, imm16};
      else
         nxt.imm = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16};
      if (opcode == OP_RTYPE) begin
         nxt.dest      = rd_idx;
         nxt.reg_write = (if_instr != '0);
      end else if ((opcode >= OP_ADDI && opcode <= OP_LUI) || opcode == OP_LW) begin
         nxt.dest      = rt_idx;
         nxt.reg_write = 1'b1;
      end else if (opcode == OP_JAL) begin
         nxt.dest      = LINK_REG;
         nxt.reg_write = 1'b1;
      end
      // Writing r0 is meaningless, so never advertise it.
      if (nxt.dest == '0) nxt.reg_write = 1'b0;
   end

   // Output register: flush wins, then capture, then drain or stall refresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q        <= '0;
         id_valid <= 1'b0;
         held_rs  <= '0;
         held_rt  <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (capture) begin
         q        <= nxt;
         id_valid <= 1'b1;
         held_rs  <= rs_idx;
         held_rt  <= rt_idx;
      end else if (id_valid && id_ready) begin
         id_valid <= 1'b0;
      end else if (id_valid && wb_live) begin
         // Stalled bundle tracks write-back so execute never sees a stale operand.
         if (wb_addr == held_rs) q.rs_data <= wb_data;
         if (wb_addr == held_rt) q.rt_data <= wb_data;
      end
   end

   assign id_pc        = q.pc;
   assign id_opcode    = q.opcode;
   assign id_funct     = q.funct;
   assign id_shamt     = q.shamt;
   assign id_rs_data   = q.rs_data;
   assign id_rt_data   = q.rt_data;
   assign id_imm       = q.imm;
   assign id_dest      = q.dest;
   assign id_reg_write = q.reg_write;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed steps then randomized traffic vs a reference model.
// Latency: model expects outputs one edge after an accepted fetch.
// Backpressure: id_ready is driven directly to exercise stalls, drains and flushes.
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_shamt;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_dest;
   logic        id_reg_write;

   int checks = 0;
   int errors = 0;

   // Reference model state: architectural registers plus the expected held instruction.
   logic [31:0] mregs [32];
   logic        m_valid;
   logic [31:0] m_pc, m_instr, m_rs, m_rt;
   logic [4:0]  m_rsi, m_rti;

   instruction_decode dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_instr(if_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_opcode(id_opcode),
      .id_funct(id_funct), .id_shamt(id_shamt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_dest(id_dest), .id_reg_write(id_reg_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_imm(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      logic [31:0] lo = {16'h0, ins[15:0]};
      if (op == 12 || op == 13 || op == 14) return lo;
      return (ins[15] ? 32'hFFFF0000 : 32'h0) | lo;
   endfunction

   function automatic logic [4:0] exp_dest(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      if (op == 0) return ins[15:11];
      if ((op >= 8 && op <= 15) || op == 35) return ins[20:16];
      if (op == 3) return 5'd31;
      return 5'd0;
   endfunction

   function automatic logic exp_rw(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      logic w = (op == 0) ? (ins != 32'h0) : (((op >= 8 && op <= 15) || op == 35 || op == 3));
      return w && (exp_dest(ins) != 5'd0);
   endfunction

   // Architectural read as seen in the current cycle, including same-cycle write-back.
   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_en && wb_addr == r) return wb_data;
      return mregs[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_rs = 32'h0; m_rt = 32'h0;
      m_rsi = 5'd0; m_rti = 5'd0;
   endtask

   task automatic compare_outputs();
      check("id_valid", 32'(id_valid), 32'(m_valid));
      if (m_valid) begin
         check("id_pc", id_pc, m_pc);
         check("id_opcode", 32'(id_opcode), 32'(m_instr[31:26]));
         check("id_funct", 32'(id_funct), 32'(m_instr[5:0]));
         check("id_shamt", 32'(id_shamt), 32'(m_instr[10:6]));
         check("id_rs_data", id_rs_data, m_rs);
         check("id_rt_data", id_rt_data, m_rt);
         check("id_imm", id_imm, exp_imm(m_instr));
         check("id_dest", 32'(id_dest), 32'(exp_dest(m_instr)));
         check("id_reg_write", 32'(id_reg_write), 32'(exp_rw(m_instr)));
      end
   endtask

   // One clock: inputs already applied at the preceding negedge.
   task automatic step();
      logic        rdy, cap, wlive;
      logic [31:0] rsv, rtv;
      #1;
      rdy = !m_valid || id_ready;
      check("if_ready", 32'(if_ready), 32'(rdy));
      cap   = if_valid && rdy && !flush;
      wlive = wb_en && wb_addr != 5'd0;
      rsv   = mread(if_instr[25:21]);
      rtv   = mread(if_instr[20:16]);
      @(posedge clk);
      if (flush) m_valid = 1'b0;
      else if (cap) begin
         m_valid = 1'b1; m_pc = if_pc; m_instr = if_instr; m_rs = rsv; m_rt = rtv;
         m_rsi = if_instr[25:21]; m_rti = if_instr[20:16];
      end else if (m_valid && id_ready) m_valid = 1'b0;
      else if (m_valid && wlive) begin
         if (wb_addr == m_rsi) m_rs = wb_data;
         if (wb_addr == m_rti) m_rt = wb_data;
      end
      if (wlive) mregs[wb_addr] = wb_data;
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle_inputs();
      if_valid = 1'b0; if_pc = 32'h0; if_instr = 32'h0; wb_en = 1'b0;
      wb_addr = 5'd0; wb_data = 32'h0; flush = 1'b0; id_ready = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
      if_valid = 1'b1; if_pc = pc; if_instr = ins;
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [5:0]  ops [12];
      ops = '{6'h00, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h04};

      // Reset state
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #2;
      check("rst_id_valid", 32'(id_valid), 32'h0);
      check("rst_if_ready", 32'(if_ready), 32'h1);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_rs_data", id_rs_data, 32'h0);
      check("rst_id_imm", id_imm, 32'h0);
      check("rst_id_reg_write", 32'(id_reg_write), 32'h0);
      @(negedge clk); rst = 1'b0;

      // All registers read zero out of reset
      for (int r = 0; r < 32; r += 2) begin
         idle_inputs(); fetch(32'h40 + 32'(r), {6'h00, 5'(r), 5'(r + 1), 5'd1, 5'd0, 6'h20});
         step();
         check("rst_reg_rs", id_rs_data, 32'h0);
         check("rst_reg_rt", id_rt_data, 32'h0);
      end

      // wb r5 then addi r6,r5,-1
      idle_inputs(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; step();
      idle_inputs(); fetch(32'h100, 32'h20A6FFFF); step();
      check("addi_rs", id_rs_data, 32'h1234);
      check("addi_imm", id_imm, 32'hFFFFFFFF);
      check("addi_dest", 32'(id_dest), 32'd6);
      check("addi_rw", 32'(id_reg_write), 32'h1);

      // ori r2,r0,0x8000
      idle_inputs(); fetch(32'h104, 32'h34028000); step();
      check("ori_imm", id_imm, 32'h00008000);

      // add r3,r1,r2 with same-cycle write of r1
      idle_inputs(); fetch(32'h108, 32'h00221820);
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; step();
      check("add_bypass_rs", id_rs_data, 32'd7);
      check("add_dest", 32'(id_dest), 32'd3);

      // Stall three cycles holding add r10,r8,r11; write r11=9 mid-stall
      idle_inputs(); fetch(32'h10C, 32'h010B5020); step();
      held_pc = id_pc;
      for (int c = 0; c < 3; c++) begin
         idle_inputs(); id_ready = 1'b0; fetch(32'h200, 32'h20A6FFFF);
         if (c == 1) begin wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'd9; end
         step();
         check("stall_if_ready", 32'(if_ready), 32'h0);
         check("stall_pc_stable", id_pc, held_pc);
      end
      check("stall_rt_refresh", id_rt_data, 32'd9);
      idle_inputs(); step();
      check("release_once", 32'(id_valid), 32'h0);
      idle_inputs(); step();

      // Flush while holding and while fetch is valid
      idle_inputs(); fetch(32'h300, 32'h3C0A1234); step();
      idle_inputs(); id_ready = 1'b0; flush = 1'b1; fetch(32'h304, 32'h20A6FFFF); step();
      check("flush_valid", 32'(id_valid), 32'h0);
      idle_inputs(); step();
      check("flush_nothing_captured", 32'(id_valid), 32'h0);

      // Write to r0 is ignored
      idle_inputs(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD; step();
      idle_inputs(); fetch(32'h400, 32'h20010000); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF; step();
      check("r0_zero", id_rs_data, 32'h0);

      // nop
      idle_inputs(); fetch(32'h404, 32'h00000000); step();
      check("nop_rw", 32'(id_reg_write), 32'h0);

      // Reset asserted mid-stall
      idle_inputs(); fetch(32'h500, 32'h20A6FFFF); step();
      idle_inputs(); id_ready = 1'b0; #2; rst = 1'b1; model_reset(); #1;
      check("midstall_rst_valid", 32'(id_valid), 32'h0);
      check("midstall_rst_rs", id_rs_data, 32'h0);
      @(negedge clk); rst = 1'b0;
      idle_inputs(); fetch(32'h504, 32'h20A6FFFF); step();
      check("post_rst_r5", id_rs_data, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ins;
         idle_inputs();
         ins = $urandom;
         ins[31:26] = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 15) == 0) ins = 32'h0;
         if_valid = ($urandom_range(0, 3) != 0);
         if_pc    = $urandom;
         if_instr = ins;
         id_ready = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 9) == 0);
         wb_en    = ($urandom_range(0, 1) == 1);
         wb_addr  = 5'($urandom_range(0, 31));
         wb_data  = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
